// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write-port arbiter with anti-starvation for B.
// Optional pending-write scoreboard (busy) when RF_ARB_SCOREBOARD_EN is defined.
module rf_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_wd,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_wd,
  output logic        b_ready,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wd,
  input  logic        alloc_valid,
  input  logic [4:0]  alloc_rd,
  output logic [31:0] busy
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] r_starve_cnt;
  logic       w_force_b;
  logic       w_grant_a;
  logic       w_grant_b;

  // Handshake: a transfer on X happens in any cycle with X_valid && X_ready;
  // ready is a same-cycle function of valid and never rises without valid.
  assign w_force_b = b_valid && (r_starve_cnt == LIMIT);
  assign w_grant_a = !rst && a_valid && !w_force_b;
  assign w_grant_b = !rst && b_valid && (!a_valid || w_force_b);

  assign a_ready = w_grant_a;
  assign b_ready = w_grant_b;

  always_comb begin
    rf_we = 1'b0;
    rf_rd = '0;
    rf_wd = '0;
    if (w_grant_a) begin
      rf_we = (a_rd != 5'd0);
      rf_rd = a_rd;
      rf_wd = a_wd;
    end else if (w_grant_b) begin
      rf_we = (b_rd != 5'd0);
      rf_rd = b_rd;
      rf_wd = b_wd;
    end
  end

  // Counts cycles B waits while requesting; any idle or served cycle resets it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (b_valid && !w_grant_b) begin
      if (r_starve_cnt != LIMIT) r_starve_cnt <= r_starve_cnt + 4'd1;
    end else begin
      r_starve_cnt <= '0;
    end
  end

`ifdef RF_ARB_SCOREBOARD_EN
  logic [31:0] r_busy;
  logic [31:0] w_set;
  logic [31:0] w_clr;

  assign w_set = alloc_valid ? (32'd1 << alloc_rd) : 32'd0;
  assign w_clr = w_grant_b ? (32'd1 << b_rd) : 32'd0;

  // Set is applied after clear so a same-cycle alloc wins; bit 0 is never set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= ((r_busy & ~w_clr) | w_set) & ~32'd1;
    end
  end

  assign busy = r_busy;
`else
  logic w_unused_alloc;
  assign w_unused_alloc = ^{alloc_valid, alloc_rd};
  assign busy = 32'h0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed-vector bench for rf_write_arbiter: driver pushes hand-computed
// expectations, a negedge monitor pops and compares the DUT outputs.
module tb_rf_write_arbiter;

`ifdef RF_ARB_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        a_valid, b_valid, alloc_valid;
  logic [4:0]  a_rd, b_rd, alloc_rd;
  logic [31:0] a_wd, b_wd;
  logic        a_ready, b_ready, rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic [31:0] busy;

  logic [71:0] exp_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  rf_write_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_wd(a_wd), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_wd(b_wd), .b_ready(b_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .busy(busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] sb(input logic [31:0] v);
    return SB_EN ? v : 32'h0;
  endfunction

  // Driver: apply one cycle of inputs and queue the expected outputs.
  task automatic step(input string nm, input logic r,
                      input logic av, input logic [4:0] ard, input logic [31:0] awd,
                      input logic bv, input logic [4:0] brd, input logic [31:0] bwd,
                      input logic alv, input logic [4:0] alrd,
                      input logic ea, input logic eb, input logic ewe,
                      input logic [4:0] erd, input logic [31:0] ewd,
                      input logic [31:0] ebusy);
    rst = r;
    a_valid = av; a_rd = ard; a_wd = awd;
    b_valid = bv; b_rd = brd; b_wd = bwd;
    alloc_valid = alv; alloc_rd = alrd;
    exp_q.push_back({ea, eb, ewe, erd, ewd, ebusy});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string nm, input logic alv, input logic [4:0] alrd,
                      input logic [31:0] ebusy);
    step(nm, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, alv, alrd, 0, 0, 0, 5'd0, 32'h0, ebusy);
  endtask

  // Both requesters valid: A = x5/AAAA, B = x7/BBBB.
  task automatic both(input string nm, input logic b_wins, input logic [31:0] ebusy);
    if (b_wins)
      step(nm, 0, 1, 5'd5, 32'hAAAA, 1, 5'd7, 32'hBBBB, 0, 5'd0,
           0, 1, 1, 5'd7, 32'hBBBB, ebusy);
    else
      step(nm, 0, 1, 5'd5, 32'hAAAA, 1, 5'd7, 32'hBBBB, 0, 5'd0,
           1, 0, 1, 5'd5, 32'hAAAA, ebusy);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [71:0] e, act;
      string nm;
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      act = {a_ready, b_ready, rf_we, rf_rd, rf_wd, busy};
      n_checks++;
      if (act === e) n_pass++;
      else
        $display("FAIL %s: got ar=%b br=%b we=%b rd=%0d wd=%h busy=%h, want ar=%b br=%b we=%b rd=%0d wd=%h busy=%h",
                 nm, act[71], act[70], act[69], act[68:64], act[63:32], act[31:0],
                 e[71], e[70], e[69], e[68:64], e[63:32], e[31:0]);
    end
  end

  initial begin
    rst = 1'b1;
    a_valid = 0; a_rd = '0; a_wd = '0;
    b_valid = 0; b_rd = '0; b_wd = '0;
    alloc_valid = 0; alloc_rd = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset holds both ready low even with both valid
    step("rst_hold", 1, 1, 5'd5, 32'h1, 1, 5'd7, 32'h2, 1, 5'd4, 0, 0, 0, 5'd0, 32'h0, 32'h0);

    // Basic grants
    step("a_only", 0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0, 5'd0,
         1, 0, 1, 5'd5, 32'hDEADBEEF, 32'h0);
    step("a_rd0", 0, 1, 5'd0, 32'h1234, 0, 5'd0, 32'h0, 0, 5'd0,
         1, 0, 0, 5'd0, 32'h1234, 32'h0);
    step("b_only", 0, 0, 5'd0, 32'h0, 1, 5'd4, 32'hB0B0, 0, 5'd0,
         0, 1, 1, 5'd4, 32'hB0B0, 32'h0);
    step("b_rd0", 0, 0, 5'd0, 32'h0, 1, 5'd0, 32'h77, 0, 5'd0,
         0, 1, 0, 5'd0, 32'h77, 32'h0);
    idle("idle0", 0, 5'd0, 32'h0);

    // Starvation: B stalled 4 cycles, wins on 5th, A wins again on 6th
    both("starve_c1", 0, 32'h0);
    both("starve_c2", 0, 32'h0);
    both("starve_c3", 0, 32'h0);
    both("starve_c4", 0, 32'h0);
    both("starve_c5_b", 1, 32'h0);
    both("starve_c6_a", 0, 32'h0);

    // A cycle with b_valid=0 discards the accumulated count
    step("b_drop", 0, 1, 5'd5, 32'hAAAA, 0, 5'd0, 32'h0, 0, 5'd0,
         1, 0, 1, 5'd5, 32'hAAAA, 32'h0);
    both("restart_c1", 0, 32'h0);
    both("restart_c2", 0, 32'h0);
    both("restart_c3", 0, 32'h0);
    both("restart_c4", 0, 32'h0);
    both("restart_c5_b", 1, 32'h0);
    idle("idle1", 0, 5'd0, 32'h0);

    // Scoreboard set and clear
    idle("alloc9", 1, 5'd9, 32'h0);
    idle("busy9", 0, 5'd0, sb(32'h200));
    step("b_clr9", 0, 0, 5'd0, 32'h0, 1, 5'd9, 32'h99, 0, 5'd0,
         0, 1, 1, 5'd9, 32'h99, sb(32'h200));
    idle("busy9_clr", 0, 5'd0, 32'h0);

    // Same-cycle set and clear of x3: set wins; alloc of x0 has no effect
    idle("alloc3", 1, 5'd3, 32'h0);
    step("alloc3_b3", 0, 0, 5'd0, 32'h0, 1, 5'd3, 32'h33, 1, 5'd3,
         0, 1, 1, 5'd3, 32'h33, sb(32'h8));
    idle("set_wins", 1, 5'd0, sb(32'h8));
    step("b_clr3", 0, 0, 5'd0, 32'h0, 1, 5'd3, 32'h34, 0, 5'd0,
         0, 1, 1, 5'd3, 32'h34, sb(32'h8));
    idle("alloc0", 1, 5'd0, 32'h0);
    idle("busy0_stays", 0, 5'd0, 32'h0);

    // A transfers leave busy alone
    idle("alloc12", 1, 5'd12, 32'h0);
    step("a_wr12", 0, 1, 5'd12, 32'hC, 0, 5'd0, 32'h0, 0, 5'd0,
         1, 0, 1, 5'd12, 32'hC, sb(32'h1000));

    // Reset mid-stall after 3 stalled cycles
    both("pre_rst_c1", 0, sb(32'h1000));
    both("pre_rst_c2", 0, sb(32'h1000));
    both("pre_rst_c3", 0, sb(32'h1000));
    step("mid_rst", 1, 1, 5'd5, 32'hAAAA, 1, 5'd7, 32'hBBBB, 0, 5'd0,
         0, 0, 0, 5'd0, 32'h0, sb(32'h1000));
    both("post_rst_c1", 0, 32'h0);
    both("post_rst_c2", 0, 32'h0);
    both("post_rst_c3", 0, 32'h0);
    both("post_rst_c4", 0, 32'h0);
    both("post_rst_c5_b", 1, 32'h0);
    idle("idle_end", 0, 5'd0, 32'h0);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: pending=%0d want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
